fifo_wr_arbiter: RTL

//  Shares the single write port of the 16-deep x 8-bit fifo among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/fifo write-side bundle shared by the arbiter and its producers.
// master = arbiter view, slave = producers plus fifo view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared fifo: one owner at a time,
// at most MAX_BURST beats per grant, write stalls while the fifo is full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                          state, state_nxt;
    logic [ID_W-1:0]                 grant_id_q, grant_id_nxt;
    logic [BC_W-1:0]                 beat_cnt, beat_cnt_nxt;
    logic [NUM_REQ-1:0][DATA_W-1:0]  data_a;
    logic [NUM_REQ-1:0]              ready;
    logic [ID_W-1:0]                 rr_owner;
    logic                            rr_hit;
    logic                            own_valid;
    logic                            xfer;
    logic [DATA_W-1:0]               din;

    assign data_a = bus.req_data;

    // Scan from the far end so the lowest offset after the pointer wins.
    always_comb begin
        int s;
        rr_owner = grant_id_q;
        rr_hit   = 1'b0;
        s        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            s = int'(grant_id_q) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (bus.req_valid[ID_W'(s)]) begin
                rr_owner = ID_W'(s);
                rr_hit   = 1'b1;
            end
        end
    end

    assign own_valid = bus.req_valid[grant_id_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id_q <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id_q <= grant_id_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_id_nxt = grant_id_q;
        beat_cnt_nxt = beat_cnt;
        xfer         = 1'b0;
        din          = '0;
        case (state)
            IDLE: begin
                if (rr_hit) begin
                    grant_id_nxt = rr_owner;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                xfer = own_valid & ~bus.fifo_full;
                if (xfer) din = data_a[grant_id_q];
                // Owner going idle releases even while the fifo is full.
                if (!own_valid) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                end else if (xfer) begin
                    if (beat_cnt == BC_W'(MAX_BURST - 1)) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign ready[i] = (state == GRANT) && (grant_id_q == ID_W'(i)) && !bus.fifo_full;
    end

    assign bus.req_ready   = ready;
    assign bus.fifo_wr_en  = xfer;
    assign bus.fifo_din    = din;
    assign bus.grant_valid = (state == GRANT);
    assign bus.grant_id    = grant_id_q;
endmodule
